clk_freq_meter: RTL

- Measures a low-quality, counter-divided clock against the reference clock.
- It is the checking end of the divided-clock scheme: it counts rising edges of clk_in over a fixed window of refclk cycles and measures the edge-to-edge period.
- It flags a frequency mismatch and a dead clock.
- Used in bring-up and health monitoring of generated clocks, with status exported to host-visible registers.

---
 rtl/clk_freq_meter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: gated edge counter and period meter for a divided clock.
// Reports window edge count, tolerance status, edge-to-edge period, dead clock.
module clk_freq_meter #(
  parameter int REF_CLK_FREQ   = 250,
  parameter int EXP_CLK_FREQ   = 10,
  parameter int GATE_CYCLES    = 250000,
  parameter int TOL            = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = $clog2(GATE_CYCLES / 2 + 1) + 1,
  localparam int PW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          clk_in,
  input  logic          enable,
  output logic [CW-1:0] edge_count,
  output logic          count_valid,
  output logic          freq_ok,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          clk_dead
);

  localparam int EXP_EDGES =
    EXP_CLK_FREQ * GATE_CYCLES / REF_CLK_FREQ;
  localparam int WW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [WW-1:0] WIN_LAST =
    WW'(GATE_CYCLES - 1);
  localparam logic [CW:0] EXP_EXT = (CW + 1)'(EXP_EDGES);
  localparam logic [CW:0] TOL_EXT = (CW + 1)'(TOL);
  localparam logic [PW-1:0] TIMEOUT_P = PW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    REPORT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          sync1;
  logic          sync2;
  logic          dly;
  logic          edge_p;
  logic [WW-1:0] win_cnt;
  logic          win_done;
  logic [CW-1:0] acc;
  logic [CW:0]   acc_ext;
  logic [CW:0]   diff;
  logic          in_tol;
  logic [PW-1:0] pcnt;
  logic          seen;

  // Bring clk_in into refclk domain and keep one delayed copy for edge detect
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign edge_p   = sync2 & ~dly;
  assign win_done = (win_cnt == WIN_LAST);

  // Measurement state register
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: dropping enable aborts a window at once
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enable)       state_nxt = IDLE;
        else if (win_done) state_nxt = REPORT;
      end
      REPORT: begin
        state_nxt = enable ? MEASURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window timer and saturating edge accumulator; a REPORT-cycle edge seeds the next window
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      acc     <= '0;
    end else begin
      unique case (state)
        MEASURE: begin
          if (!enable) begin
            win_cnt <= '0;
            acc     <= '0;
          end else begin
            win_cnt <= win_done ? '0 : win_cnt + 1'b1;
            if (edge_p && acc != '1) acc <= acc + 1'b1;
          end
        end
        REPORT: begin
          win_cnt <= '0;
          acc     <= {{(CW-1){1'b0}}, edge_p};
        end
        default: begin
          win_cnt <= '0;
          acc     <= '0;
        end
      endcase
    end
  end

  assign acc_ext = {1'b0, acc};
  assign diff    = (acc_ext >= EXP_EXT) ? acc_ext - EXP_EXT
                                        : EXP_EXT - acc_ext;
  assign in_tol  = (diff <= TOL_EXT);

  // Latch the window result; count_valid lines up with the new values
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      edge_count  <= '0;
      freq_ok     <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= (state == REPORT);
      if (state == REPORT) begin
        edge_count <= acc;
        freq_ok    <= in_tol;
      end
    end
  end

  // Edge-to-edge period; the first edge after enable only arms the measurement
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pcnt         <= '0;
      seen         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        pcnt <= '0;
        seen <= 1'b0;
      end else if (edge_p) begin
        pcnt <= PW'(1);
        seen <= 1'b1;
        if (seen) begin
          period       <= pcnt;
          period_valid <= 1'b1;
        end
      end else if (pcnt != '1) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // The counter saturates above the timeout, so it stays dead until an edge
  assign clk_dead = enable & ~edge_p & (pcnt >= TIMEOUT_P);

endmodule
